// File: rtl/logic_capture_pkg.sv
// Shared definitions for the trigger-based logic capture engine:
// FSM state encoding, trigger modes and register-field bit positions.
package logic_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ARMED = 2'b01,
    ST_POST  = 2'b10,
    ST_DONE  = 2'b11
  } state_t;

  localparam logic [1:0] MODE_IMM    = 2'b00;
  localparam logic [1:0] MODE_LEVEL  = 2'b01;
  localparam logic [1:0] MODE_CHANGE = 2'b10;
  localparam logic [1:0] MODE_EDGE   = 2'b11;

  localparam int CTRL_START     = 0;
  localparam int CTRL_ABORT     = 1;
  localparam int STAT_STATE_LSB = 30;
  localparam int STAT_WRAPPED   = 29;
  localparam int STAT_TRIG_SEEN = 28;
  localparam int CFG0_VALUE_LSB = 0;
  localparam int CFG0_MASK_LSB  = 16;
  localparam int CFG1_MODE_LSB  = 28;

endpackage

// File: rtl/logic_capture_trig_match.sv
// Probe input stage (samp / samp_prev registers) and trigger condition
// evaluation for the four trigger modes.
module logic_capture_trig_match #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] datain,
  input  logic [DATA_W-1:0] mask,
  input  logic [DATA_W-1:0] value,
  input  logic [1:0]        mode,
  input  logic              prev_valid,
  output logic [DATA_W-1:0] samp,
  output logic              trig_hit
);
  import logic_capture_pkg::*;

  logic [DATA_W-1:0] samp_reg;
  logic [DATA_W-1:0] samp_prev_reg;
  logic [DATA_W-1:0] cur_eq;
  logic [DATA_W-1:0] prev_eq;
  logic              cur_lvl;
  logic              prev_lvl;
  logic              changed;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      samp_reg      <= '0;
      samp_prev_reg <= '0;
    end else begin
      samp_reg      <= datain;
      samp_prev_reg <= samp_reg;
    end
  end

  // Masked-out bits always count as matching.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_bit
      assign cur_eq[gi]  = ~mask[gi] | (samp_reg[gi] ~^ value[gi]);
      assign prev_eq[gi] = ~mask[gi] | (samp_prev_reg[gi] ~^ value[gi]);
    end
  endgenerate

  assign cur_lvl  = &cur_eq;
  assign prev_lvl = &prev_eq;
  assign changed  = |((samp_reg ^ samp_prev_reg) & mask);

  always_comb begin
    trig_hit = 1'b0;
    case (mode)
      MODE_IMM:    trig_hit = ~prev_valid;
      MODE_LEVEL:  trig_hit = cur_lvl;
      MODE_CHANGE: trig_hit = prev_valid & changed;
      default:     trig_hit = prev_valid & cur_lvl & ~prev_lvl;
    endcase
  end

  assign samp = samp_reg;

endmodule

// File: rtl/logic_capture_trig.sv
// Trigger-based logic capture engine: streams probe samples into a circular
// RAM window, keeps pre-trigger history and stops N samples after the trigger.
module logic_capture_trig #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              resetn,
  output logic [31:0]       status,
  input  logic [31:0]       control,
  input  logic [31:0]       config0,
  input  logic [31:0]       config1,
  input  logic [DATA_W-1:0] datain,
  output logic [DATA_W-1:0] dataout,
  output logic              we,
  output logic              en,
  output logic [ADDR_W-1:0] address
);
  import logic_capture_pkg::*;

  localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

  state_t            state_reg, state_next;
  logic              start_prev_reg, start_prev_next;
  logic              prev_valid_reg, prev_valid_next;
  logic [ADDR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] dout_reg, dout_next;
  logic              we_reg, we_next;
  logic              wrapped_reg, wrapped_next;
  logic              trig_seen_reg, trig_seen_next;
  logic [ADDR_W-1:0] trig_addr_reg, trig_addr_next;
  logic [ADDR_W-1:0] cnt_reg, cnt_next;
  logic [DATA_W-1:0] mask_reg, mask_next;
  logic [DATA_W-1:0] value_reg, value_next;
  logic [1:0]        mode_reg, mode_next;
  logic [ADDR_W-1:0] n_reg, n_next;

  logic [DATA_W-1:0] samp;
  logic              trig_hit;
  logic              start_edge;
  logic              abort;
  logic              unused_inputs;

  logic_capture_trig_match #(.DATA_W(DATA_W)) u_match (
    .clk        (clk),
    .resetn     (resetn),
    .datain     (datain),
    .mask       (mask_reg),
    .value      (value_reg),
    .mode       (mode_reg),
    .prev_valid (prev_valid_reg),
    .samp       (samp),
    .trig_hit   (trig_hit)
  );

  assign start_edge    = control[CTRL_START] & ~start_prev_reg;
  assign abort         = control[CTRL_ABORT];
  assign unused_inputs = ^{control, config0, config1};

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      start_prev_reg <= 1'b0;
      prev_valid_reg <= 1'b0;
      wr_ptr_reg     <= '0;
      addr_reg       <= '0;
      dout_reg       <= '0;
      we_reg         <= 1'b0;
      wrapped_reg    <= 1'b0;
      trig_seen_reg  <= 1'b0;
      trig_addr_reg  <= '0;
      cnt_reg        <= '0;
      mask_reg       <= '0;
      value_reg      <= '0;
      mode_reg       <= '0;
      n_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      start_prev_reg <= start_prev_next;
      prev_valid_reg <= prev_valid_next;
      wr_ptr_reg     <= wr_ptr_next;
      addr_reg       <= addr_next;
      dout_reg       <= dout_next;
      we_reg         <= we_next;
      wrapped_reg    <= wrapped_next;
      trig_seen_reg  <= trig_seen_next;
      trig_addr_reg  <= trig_addr_next;
      cnt_reg        <= cnt_next;
      mask_reg       <= mask_next;
      value_reg      <= value_next;
      mode_reg       <= mode_next;
      n_reg          <= n_next;
    end
  end

  // RAM port is registered: a sample in samp is presented one cycle later and
  // committed at the following edge; address shows the next-write slot when idle.
  always_comb begin
    state_next      = state_reg;
    start_prev_next = control[CTRL_START];
    prev_valid_next = prev_valid_reg;
    wr_ptr_next     = wr_ptr_reg;
    addr_next       = wr_ptr_reg;
    dout_next       = dout_reg;
    we_next         = 1'b0;
    wrapped_next    = wrapped_reg;
    trig_seen_next  = trig_seen_reg;
    trig_addr_next  = trig_addr_reg;
    cnt_next        = cnt_reg;
    mask_next       = mask_reg;
    value_next      = value_reg;
    mode_next       = mode_reg;
    n_next          = n_reg;

    if (abort) begin
      state_next      = ST_IDLE;
      prev_valid_next = 1'b0;
      wrapped_next    = 1'b0;
      trig_seen_next  = 1'b0;
      trig_addr_next  = '0;
    end else begin
      if (state_reg == ST_ARMED || state_reg == ST_POST) begin
        we_next     = 1'b1;
        dout_next   = samp;
        addr_next   = wr_ptr_reg;
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (start_edge) begin
            state_next      = ST_ARMED;
            prev_valid_next = 1'b0;
            wr_ptr_next     = '0;
            addr_next       = '0;
            wrapped_next    = 1'b0;
            trig_seen_next  = 1'b0;
            trig_addr_next  = '0;
            value_next      = config0[CFG0_VALUE_LSB +: DATA_W];
            mask_next       = config0[CFG0_MASK_LSB +: DATA_W];
            mode_next       = config1[CFG1_MODE_LSB +: 2];
            // An ADDR_W-bit count is already capped at DEPTH-1.
            n_next          = config1[ADDR_W-1:0];
          end
        end
        ST_ARMED: begin
          prev_valid_next = 1'b1;
          if (wr_ptr_reg == '1) wrapped_next = 1'b1;
          if (trig_hit) begin
            trig_addr_next = wr_ptr_reg;
            trig_seen_next = 1'b1;
            cnt_next       = n_reg;
            state_next     = (n_reg == '0) ? ST_DONE : ST_POST;
          end
        end
        ST_POST: begin
          cnt_next = cnt_reg - 1'b1;
          if (cnt_reg == CNT_ONE) state_next = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    status                       = '0;
    status[STAT_STATE_LSB +: 2]  = state_reg;
    status[STAT_WRAPPED]         = wrapped_reg;
    status[STAT_TRIG_SEEN]       = trig_seen_reg;
    status[ADDR_W-1:0]           = trig_addr_reg;
  end

  assign dataout = dout_reg;
  assign we      = we_reg;
  assign en      = we_reg;
  assign address = addr_reg;

endmodule

// File: tb/tb_logic_capture_trig.sv
// Self-checking bench for logic_capture_trig (DATA_W=8, ADDR_W=4): directed
// scenarios plus randomized captures against a sample-stream reference model.
module tb_logic_capture_trig;

  logic        clk = 1'b0;
  logic        resetn;
  logic [31:0] status;
  logic [31:0] control;
  logic [31:0] config0;
  logic [31:0] config1;
  logic [7:0]  datain;
  logic [7:0]  dataout;
  logic        we;
  logic        en;
  logic [3:0]  address;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] driven_q[$];
  logic [3:0] wr_addr_q[$];
  logic [7:0] wr_data_q[$];
  logic       wr_en_q[$];

  logic_capture_trig #(.DATA_W(8), .ADDR_W(4)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .status  (status),
    .control (control),
    .config0 (config0),
    .config1 (config1),
    .datain  (datain),
    .dataout (dataout),
    .we      (we),
    .en      (en),
    .address (address)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (resetn && we) begin
      wr_addr_q.push_back(address);
      wr_data_q.push_back(dataout);
      wr_en_q.push_back(en);
    end
  end

  function automatic logic [31:0] mk_status(input logic [1:0] st, input bit wr, input bit seen, input int ta);
    return {st, wr, seen, 24'h0, 4'(ta)};
  endfunction

  // Index of the first sample (counted from the first armed sample) that fires.
  function automatic int model_trig(input logic [1:0] mode, input logic [7:0] m, input logic [7:0] v,
                                    input logic [7:0] s[$]);
    bit hit, lvl, plvl, chg;
    for (int i = 0; i < s.size(); i++) begin
      lvl  = ((s[i] & m) == (v & m));
      plvl = 1'b0;
      chg  = 1'b0;
      if (i > 0) begin
        plvl = ((s[i-1] & m) == (v & m));
        chg  = ((s[i] ^ s[i-1]) & m) != 8'h00;
      end
      case (mode)
        2'd0:    hit = (i == 0);
        2'd1:    hit = lvl;
        2'd2:    hit = (i > 0) && chg;
        default: hit = (i > 0) && lvl && !plvl;
      endcase
      if (hit) return i;
    end
    return -1;
  endfunction

  // Starts one capture, feeds seq (then random filler) and waits for DONE with
  // the last write committed. Perturbs config and re-pulses start mid-capture.
  task automatic do_capture(input logic [31:0] c0, input logic [31:0] c1,
                            input logic [7:0] seq[$], output bit timed_out);
    logic [7:0] d;
    @(posedge clk); #1;
    control = 32'h0;
    @(posedge clk); #1;
    driven_q.delete(); wr_addr_q.delete(); wr_data_q.delete(); wr_en_q.delete();
    config0 = c0;
    config1 = c1;
    d = (seq.size() > 0) ? seq[0] : 8'($urandom);
    datain = d;
    driven_q.push_back(d);
    control = 32'h1;
    timed_out = 1'b1;
    for (int cyc = 1; cyc < 300; cyc++) begin
      @(posedge clk); #1;
      control = 32'h0;
      if (cyc == 1) begin
        config0 = $urandom;
        config1 = $urandom;
      end
      if (status[31:30] == 2'b11 && we == 1'b0) begin
        timed_out = 1'b0;
        break;
      end
      if (cyc == 3 && (status[31:30] == 2'b01 || status[31:30] == 2'b10)) control = 32'h1;
      d = (cyc < seq.size()) ? seq[cyc] : 8'($urandom);
      datain = d;
      driven_q.push_back(d);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0; control = 32'h0; config0 = 32'h0; config1 = 32'h0; datain = 8'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (status !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h expected %h", status, 32'h0); end
    n_tests++; if (we !== 1'b0 || en !== 1'b0) begin n_fail++; $display("FAIL reset_we_en: got %b%b expected 00", we, en); end
    n_tests++; if (address !== 4'h0 || dataout !== 8'h0) begin n_fail++; $display("FAIL reset_addr_data: got %h/%h expected 0/00", address, dataout); end
    @(negedge clk) resetn = 1'b1;
    @(posedge clk); #1;
    n_tests++; if (status !== 32'h0 || we !== 1'b0) begin n_fail++; $display("FAIL reset_idle: got %h we=%b expected 0 we=0", status, we); end
    $display("[TB] reset checked");
  endtask

  task automatic test_immediate();
    logic [7:0] seq[$];
    bit to;
    int n;
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    do_capture(32'h0, 32'h0000_0003, seq, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL imm_timeout: got timeout expected DONE"); end
    n_tests++; if (status !== mk_status(2'b11, 0, 1, 0)) begin n_fail++; $display("FAIL imm_status: got %h expected %h", status, mk_status(2'b11, 0, 1, 0)); end
    n_tests++; if (address !== 4'd4) begin n_fail++; $display("FAIL imm_address: got %0d expected 4", address); end
    n_tests++; if (wr_addr_q.size() != 4) begin n_fail++; $display("FAIL imm_count: got %0d expected 4", wr_addr_q.size()); end
    n = (wr_addr_q.size() < 4) ? wr_addr_q.size() : 4;
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (wr_addr_q[i] !== 4'(i) || wr_data_q[i] !== driven_q[i] || wr_en_q[i] !== 1'b1) begin
        n_fail++; $display("FAIL imm_write%0d: got a=%0d d=%h en=%b expected a=%0d d=%h en=1", i, wr_addr_q[i], wr_data_q[i], wr_en_q[i], i, driven_q[i]);
      end
    end
    $display("[TB] immediate capture status=%h address=%0d", status, address);
  endtask

  task automatic test_level();
    logic [7:0] seq[$];
    bit to;
    int n;
    seq = '{8'd3, 8'd1, 8'd2, 8'd1, 8'd7, 8'd123, 8'd1, 8'd33};
    do_capture(32'h00FF_007B, 32'h1000_0002, seq, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL lvl_timeout: got timeout expected DONE"); end
    n_tests++; if (status !== mk_status(2'b11, 0, 1, 5)) begin n_fail++; $display("FAIL lvl_status: got %h expected %h", status, mk_status(2'b11, 0, 1, 5)); end
    n_tests++; if (address !== 4'd8) begin n_fail++; $display("FAIL lvl_address: got %0d expected 8", address); end
    n_tests++; if (wr_addr_q.size() != 8) begin n_fail++; $display("FAIL lvl_count: got %0d expected 8", wr_addr_q.size()); end
    n = (wr_addr_q.size() < 8) ? wr_addr_q.size() : 8;
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (wr_addr_q[i] !== 4'(i) || wr_data_q[i] !== seq[i]) begin
        n_fail++; $display("FAIL lvl_write%0d: got a=%0d d=%h expected a=%0d d=%h", i, wr_addr_q[i], wr_data_q[i], i, seq[i]);
      end
    end
    $display("[TB] level capture status=%h address=%0d", status, address);
  endtask

  task automatic test_level_wrap();
    logic [7:0] seq[$];
    logic [7:0] x;
    bit to;
    int n;
    for (int i = 0; i < 20; i++) begin
      x = 8'($urandom);
      if (x == 8'hAA) x = 8'h55;
      seq.push_back(x);
    end
    seq.push_back(8'hAA);
    do_capture(32'h00FF_00AA, 32'h1000_0001, seq, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL wrap_timeout: got timeout expected DONE"); end
    n_tests++; if (status !== mk_status(2'b11, 1, 1, 4)) begin n_fail++; $display("FAIL wrap_status: got %h expected %h", status, mk_status(2'b11, 1, 1, 4)); end
    n_tests++; if (address !== 4'd6) begin n_fail++; $display("FAIL wrap_address: got %0d expected 6", address); end
    n_tests++; if (wr_addr_q.size() != 22) begin n_fail++; $display("FAIL wrap_count: got %0d expected 22", wr_addr_q.size()); end
    n = (wr_addr_q.size() < 22) ? wr_addr_q.size() : 22;
    for (int i = 0; i < n; i++) begin
      n_tests++;
      if (wr_addr_q[i] !== 4'(i % 16) || wr_data_q[i] !== driven_q[i]) begin
        n_fail++; $display("FAIL wrap_write%0d: got a=%0d d=%h expected a=%0d d=%h", i, wr_addr_q[i], wr_data_q[i], i % 16, driven_q[i]);
      end
    end
    $display("[TB] level wrap capture status=%h address=%0d", status, address);
  endtask

  task automatic test_change();
    logic [7:0] seq[$];
    bit to;
    seq = '{8'h03, 8'h02, 8'h02};
    do_capture(32'h0001_0000, 32'h2000_0000, seq, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL chg_timeout: got timeout expected DONE"); end
    n_tests++; if (status !== mk_status(2'b11, 0, 1, 1)) begin n_fail++; $display("FAIL chg_status: got %h expected %h", status, mk_status(2'b11, 0, 1, 1)); end
    n_tests++; if (address !== 4'd2 || wr_addr_q.size() != 2) begin n_fail++; $display("FAIL chg_address: got %0d/%0d writes expected 2/2", address, wr_addr_q.size()); end
    $display("[TB] change capture status=%h address=%0d", status, address);
  endtask

  task automatic test_edge();
    logic [7:0] seq[$];
    bit to;
    seq = '{8'h01, 8'h01, 8'h00, 8'h01};
    do_capture(32'h0001_0001, 32'h3000_0000, seq, to);
    n_tests++; if (to) begin n_fail++; $display("FAIL edge_timeout: got timeout expected DONE"); end
    n_tests++; if (status !== mk_status(2'b11, 0, 1, 3)) begin n_fail++; $display("FAIL edge_status: got %h expected %h", status, mk_status(2'b11, 0, 1, 3)); end
    n_tests++; if (address !== 4'd4 || wr_addr_q.size() != 4) begin n_fail++; $display("FAIL edge_address: got %0d/%0d writes expected 4/4", address, wr_addr_q.size()); end
    $display("[TB] edge capture status=%h address=%0d", status, address);
  endtask

  task automatic test_random();
    logic [7:0] seq[$];
    logic [1:0] mode;
    logic [7:0] m, v, x;
    logic [3:0] nn;
    int pre, t, n;
    bit to;
    for (int it = 0; it < 12; it++) begin
      seq.delete();
      mode = 2'($urandom_range(0, 3));
      m    = 8'(1 << $urandom_range(0, 7)) | 8'(1 << $urandom_range(0, 7));
      v    = 8'($urandom);
      nn   = 4'($urandom_range(0, 15));
      pre  = (mode == 2'd1 || mode == 2'd3) ? $urandom_range(0, 30) : 0;
      for (int k = 0; k < pre; k++) begin
        x = 8'($urandom);
        if ((x & m) == (v & m)) x = x ^ m;
        seq.push_back(x);
      end
      do_capture({8'h0, m, 8'h0, v}, {2'b00, mode, 24'h0, nn}, seq, to);
      t = model_trig(mode, m, v, driven_q);
      n_tests++;
      if (to || t < 0) begin
        n_fail++; $display("FAIL rnd%0d_done: got timeout=%0b model_idx=%0d expected DONE", it, to, t);
        continue;
      end
      n_tests++;
      if (status !== mk_status(2'b11, t >= 15, 1, t % 16)) begin
        n_fail++; $display("FAIL rnd%0d_status: got %h expected %h", it, status, mk_status(2'b11, t >= 15, 1, t % 16));
      end
      n_tests++;
      if (address !== 4'((t + nn + 1) % 16) || wr_addr_q.size() != t + nn + 1) begin
        n_fail++; $display("FAIL rnd%0d_addr: got %0d/%0d writes expected %0d/%0d", it, address, wr_addr_q.size(), (t + nn + 1) % 16, t + nn + 1);
      end
      n = (wr_addr_q.size() < t + nn + 1) ? wr_addr_q.size() : t + nn + 1;
      for (int i = 0; i < n; i++) begin
        n_tests++;
        if (wr_addr_q[i] !== 4'(i % 16) || wr_data_q[i] !== driven_q[i]) begin
          n_fail++; $display("FAIL rnd%0d_write%0d: got a=%0d d=%h expected a=%0d d=%h", it, i, wr_addr_q[i], wr_data_q[i], i % 16, driven_q[i]);
        end
      end
      $display("[TB] random capture %0d mode=%0d mask=%h value=%h n=%0d trig_idx=%0d status=%h", it, mode, m, v, nn, t, status);
    end
  endtask

  task automatic test_abort();
    @(posedge clk); #1;
    control = 32'h0;
    @(posedge clk); #1;
    config0 = 32'h0; config1 = 32'h0000_0008; datain = 8'h5A; control = 32'h1;
    @(posedge clk); #1;
    control = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++; if (status[31:30] !== 2'b10) begin n_fail++; $display("FAIL abort_pre_post: got state %b expected 10", status[31:30]); end
    control = 32'h2;
    @(posedge clk); #1;
    n_tests++; if (status !== 32'h0) begin n_fail++; $display("FAIL abort_status: got %h expected 0", status); end
    n_tests++; if (we !== 1'b0 || en !== 1'b0) begin n_fail++; $display("FAIL abort_we: got %b%b expected 00", we, en); end
    control = 32'h0;
    @(posedge clk); #1;
    control = 32'h3;
    @(posedge clk); #1;
    control = 32'h0;
    @(posedge clk); #1;
    n_tests++; if (status !== 32'h0 || we !== 1'b0) begin n_fail++; $display("FAIL abort_over_start: got %h we=%b expected 0 we=0", status, we); end
    $display("[TB] abort checked status=%h", status);
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    config0 = 32'h00FF_00AA; config1 = 32'h1000_0004; datain = 8'h33; control = 32'h1;
    @(posedge clk); #1;
    control = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    n_tests++; if (status[31:30] !== 2'b01 || we !== 1'b1) begin n_fail++; $display("FAIL rstmid_armed: got state %b we=%b expected 01 we=1", status[31:30], we); end
    #2 resetn = 1'b0;
    #1;
    n_tests++; if (status !== 32'h0 || we !== 1'b0 || en !== 1'b0) begin n_fail++; $display("FAIL rstmid_async: got %h we=%b en=%b expected 0 0 0", status, we, en); end
    n_tests++; if (address !== 4'h0 || dataout !== 8'h0) begin n_fail++; $display("FAIL rstmid_port: got %h/%h expected 0/00", address, dataout); end
    @(negedge clk) resetn = 1'b1;
    $display("[TB] mid-capture reset checked");
  endtask

  initial begin
    test_reset();
    test_immediate();
    test_level();
    test_level_wrap();
    test_change();
    test_edge();
    test_random();
    test_abort();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
